// File: rtl/game_pkg.sv
// Shared definitions for the game datapath blocks.
//   - hp_state_e : player health controller states
//   - HP_W/hp_t  : hit-point width and type
//   - pos_t      : packed sprite position, x in [19:10], y in [9:0]
package game_pkg;

    localparam int HP_W = 4;
    typedef logic [HP_W-1:0] hp_t;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } hp_state_e;

    localparam int POS_W     = 20;
    localparam int POS_X_MSB = 19;
    localparam int POS_X_LSB = 10;
    localparam int POS_Y_MSB = 9;
    localparam int POS_Y_LSB = 0;
    typedef logic [POS_W-1:0] pos_t;

    function automatic logic [9:0] pos_x(input pos_t p);
        return p[POS_X_MSB:POS_X_LSB];
    endfunction

    function automatic logic [9:0] pos_y(input pos_t p);
        return p[POS_Y_MSB:POS_Y_LSB];
    endfunction

    // +1 that holds at the ceiling instead of wrapping.
    function automatic hp_t hp_sat_inc(input hp_t hp, input hp_t max_hp);
        return (hp >= max_hp) ? max_hp : hp + hp_t'(1);
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter advanced by a frame strobe. Holds at zero.
// Ports:
//   clk, rst_n  : clock, async active-low reset (clears to 0)
//   clr         : synchronous clear, highest priority
//   load        : load load_value (beats en)
//   load_value  : reload value
//   en          : decrement enable (frame tick)
//   value       : current count
//   zero        : value == 0
module frame_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/player_health_ctrl.sv
// Player hit-point owner. Turns the collision level into discrete hits,
// runs a blinking invulnerability window after a non-fatal hit and flags
// game over.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   frame_tick      : one-clk strobe per video frame
//   enemy_collide   : raw collision level (registered before use)
//   heal_req        : one-clk strobe, +1 hp (saturating)
//   restart         : one-clk strobe, revive with full hp
//   hp              : current hit points
//   hit_pulse       : one-clk strobe when damage is applied
//   invuln          : high during the invulnerability window
//   sprite_visible  : player sprite enable
//   game_over       : high while dead
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_ALIVE   | vulnerable, a registered collision costs DAMAGE
// ST_INVULN  | post-hit window, collisions ignored, sprite blinks
// ST_DEAD    | hp is 0, waits for restart
module player_health_ctrl
    import game_pkg::*;
#(
    parameter int MAX_HP        = 5,
    parameter int DAMAGE        = 1,
    parameter int INVULN_FRAMES = 90,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            frame_tick,
    input  logic            enemy_collide,
    input  logic            heal_req,
    input  logic            restart,
    output logic [HP_W-1:0] hp,
    output logic            hit_pulse,
    output logic            invuln,
    output logic            sprite_visible,
    output logic            game_over
);

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    localparam hp_t             MAX_HP_C = hp_t'(MAX_HP);
    localparam hp_t             DMG_C    = hp_t'(DAMAGE);
    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLINK_FRAMES);

    hp_state_e state_q;
    hp_t       hp_q;
    logic      coll_q;
    logic      hit_pulse_q;
    logic      invuln_q;
    logic      visible_q;
    logic      game_over_q;

    logic [INV_W-1:0] inv_val;
    logic             inv_zero;
    logic [BLK_W-1:0] blk_val;
    logic             blk_zero;

    logic hit_take;
    logic hit_survive;
    logic tick_en;
    logic inv_expire;
    logic blink_wrap;

    assign hit_take    = (state_q == ST_ALIVE) && coll_q && !restart;
    assign hit_survive = hit_take && (hp_q > DMG_C);
    assign tick_en     = (state_q == ST_INVULN) && frame_tick && !restart;
    // The zero terms only matter if a counter were somehow already empty
    // in INVULN; they keep the FSM from getting stuck there.
    assign inv_expire  = tick_en && ((inv_val == INV_W'(1)) || inv_zero);
    assign blink_wrap  = tick_en && ((blk_val == BLK_W'(1)) || blk_zero);

    frame_down_counter #(.WIDTH(INV_W)) u_inv_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .load       (hit_survive),
        .load_value (INV_LOAD),
        .en         (tick_en),
        .value      (inv_val),
        .zero       (inv_zero)
    );

    frame_down_counter #(.WIDTH(BLK_W)) u_blink_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .load       (hit_survive || blink_wrap),
        .load_value (BLK_LOAD),
        .en         (tick_en),
        .value      (blk_val),
        .zero       (blk_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ALIVE;
            hp_q        <= MAX_HP_C;
            coll_q      <= 1'b0;
            hit_pulse_q <= 1'b0;
            invuln_q    <= 1'b0;
            visible_q   <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            coll_q      <= enemy_collide;
            hit_pulse_q <= 1'b0;
            if (restart) begin
                state_q     <= ST_ALIVE;
                hp_q        <= MAX_HP_C;
                invuln_q    <= 1'b0;
                visible_q   <= 1'b1;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ALIVE: begin
                        // A hit wins over a same-cycle heal; the heal is lost.
                        if (hit_take) begin
                            hit_pulse_q <= 1'b1;
                            visible_q   <= 1'b0;
                            if (hit_survive) begin
                                hp_q     <= hp_q - DMG_C;
                                state_q  <= ST_INVULN;
                                invuln_q <= 1'b1;
                            end else begin
                                hp_q        <= '0;
                                state_q     <= ST_DEAD;
                                game_over_q <= 1'b1;
                            end
                        end else if (heal_req) begin
                            hp_q <= hp_sat_inc(hp_q, MAX_HP_C);
                        end
                    end
                    ST_INVULN: begin
                        if (heal_req) begin
                            hp_q <= hp_sat_inc(hp_q, MAX_HP_C);
                        end
                        if (inv_expire) begin
                            state_q   <= ST_ALIVE;
                            invuln_q  <= 1'b0;
                            visible_q <= 1'b1;
                        end else if (blink_wrap) begin
                            visible_q <= ~visible_q;
                        end
                    end
                    ST_DEAD: begin
                        game_over_q <= 1'b1;
                        visible_q   <= 1'b0;
                    end
                    default: begin
                        state_q   <= ST_ALIVE;
                        invuln_q  <= 1'b0;
                        visible_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign hp             = hp_q;
    assign hit_pulse      = hit_pulse_q;
    assign invuln         = invuln_q;
    assign sprite_visible = visible_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_player_health_ctrl.sv
// Directed bench for player_health_ctrl with default parameters
// (MAX_HP=5, DAMAGE=1, INVULN_FRAMES=90, BLINK_FRAMES=8).
module tb_player_health_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enemy_collide = 1'b0;
    logic       heal_req = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] hp;
    logic       hit_pulse;
    logic       invuln;
    logic       sprite_visible;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    player_health_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .enemy_collide  (enemy_collide),
        .heal_req       (heal_req),
        .restart        (restart),
        .hp             (hp),
        .hit_pulse      (hit_pulse),
        .invuln         (invuln),
        .sprite_visible (sprite_visible),
        .game_over      (game_over)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame_pulse(input int idle);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (idle) step();
    endtask

    task automatic hit_once();
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        step();
    endtask

    task automatic run_invuln();
        repeat (90) frame_pulse(1);
        chk("invuln_done", {31'd0, invuln}, 0);
        chk("invuln_done_vis", {31'd0, sprite_visible}, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hp"}, {28'd0, hp}, 5);
        chk({tag, "_hit"}, {31'd0, hit_pulse}, 0);
        chk({tag, "_inv"}, {31'd0, invuln}, 0);
        chk({tag, "_vis"}, {31'd0, sprite_visible}, 1);
        chk({tag, "_go"}, {31'd0, game_over}, 0);
    endtask

    initial begin
        int exp_hp;
        int ticks;
        int hits;
        int cyc;
        int extra;

        // Reset values while reset held, then after release
        #12;
        chk_reset_vals("rst");
        #11 rst_n = 1'b1;
        step();
        chk_reset_vals("rst_rel");

        // Single-cycle collision: hit lands one edge after sampling
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        chk("lat_n_hit", {31'd0, hit_pulse}, 0);
        chk("lat_n_hp", {28'd0, hp}, 5);
        step();
        chk("hit1_pulse", {31'd0, hit_pulse}, 1);
        chk("hit1_hp", {28'd0, hp}, 4);
        chk("hit1_inv", {31'd0, invuln}, 1);
        chk("hit1_vis", {31'd0, sprite_visible}, 0);
        chk("hit1_go", {31'd0, game_over}, 0);
        step();
        chk("hit1_pulse_end", {31'd0, hit_pulse}, 0);

        // Blink every 8 ticks, window ends on tick 90 with sprite shown
        for (int k = 1; k <= 90; k++) begin
            frame_pulse(1);
            chk("blink_inv", {31'd0, invuln}, (k < 90) ? 1 : 0);
            chk("blink_vis", {31'd0, sprite_visible}, (k >= 90) ? 1 : ((k / 8) % 2));
            chk("blink_hp", {28'd0, hp}, 4);
        end
        frame_pulse(1);
        chk("alive_tick_inv", {31'd0, invuln}, 0);
        chk("alive_tick_vis", {31'd0, sprite_visible}, 1);

        // Heal saturates at MAX_HP
        heal_req = 1'b1; step(); heal_req = 1'b0;
        chk("heal1", {28'd0, hp}, 5);
        heal_req = 1'b1; step(); heal_req = 1'b0;
        chk("heal_sat", {28'd0, hp}, 5);

        // Heal during INVULN
        hit_once();
        chk("hit2_hp", {28'd0, hp}, 4);
        heal_req = 1'b1; step(); heal_req = 1'b0;
        chk("heal_inv_hp", {28'd0, hp}, 5);
        chk("heal_inv_inv", {31'd0, invuln}, 1);
        run_invuln();
        hit_once();
        chk("hit3_hp", {28'd0, hp}, 4);
        run_invuln();
        hit_once();
        chk("hit4_hp", {28'd0, hp}, 3);
        run_invuln();

        // Same-cycle hit and heal at hp=3: hit only
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        heal_req = 1'b1;
        step();
        heal_req = 1'b0;
        chk("hitheal_hp", {28'd0, hp}, 2);
        chk("hitheal_pulse", {31'd0, hit_pulse}, 1);
        step();
        chk("hitheal_noq", {28'd0, hp}, 2);

        // Restart out of INVULN
        restart = 1'b1; step(); restart = 1'b0;
        chk_reset_vals("rs_inv");

        // Restart beats a same-cycle hit
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_hit_hp", {28'd0, hp}, 5);
        chk("rs_hit_pulse", {31'd0, hit_pulse}, 0);
        chk("rs_hit_inv", {31'd0, invuln}, 0);
        step();
        chk("rs_hit_pulse2", {31'd0, hit_pulse}, 0);
        chk("rs_hit_hp2", {28'd0, hp}, 5);

        // Sustained contact, frame tick every 10 clks
        exp_hp = 5;
        ticks = 0;
        hits = 0;
        cyc = 0;
        enemy_collide = 1'b1;
        while (hits < 5 && cyc < 6000) begin
            frame_tick = ((cyc % 10) == 9);
            if (frame_tick) ticks++;
            step();
            frame_tick = 1'b0;
            cyc++;
            if (hit_pulse) begin
                hits++;
                exp_hp--;
                chk("sus_hp", {28'd0, hp}, exp_hp);
                chk("sus_go", {31'd0, game_over}, (exp_hp == 0) ? 1 : 0);
                chk("sus_inv", {31'd0, invuln}, (exp_hp != 0) ? 1 : 0);
                if (hits > 1) chk("sus_ticks", ticks, 90);
                ticks = 0;
            end
        end
        chk("sus_hits", hits, 5);

        // DEAD: contact, ticks and heals do nothing
        extra = 0;
        for (int c = 0; c < 200; c++) begin
            frame_tick = ((c % 10) == 9);
            heal_req = ((c % 7) == 3);
            step();
            frame_tick = 1'b0;
            heal_req = 1'b0;
            if (hit_pulse) extra++;
        end
        enemy_collide = 1'b0;
        chk("dead_pulses", extra, 0);
        chk("dead_hp", {28'd0, hp}, 0);
        chk("dead_go", {31'd0, game_over}, 1);
        chk("dead_vis", {31'd0, sprite_visible}, 0);
        chk("dead_inv", {31'd0, invuln}, 0);
        restart = 1'b1; step(); restart = 1'b0;
        chk_reset_vals("rs_dead");

        // Glitch between edges is never sampled
        #2 enemy_collide = 1'b1;
        #3 enemy_collide = 1'b0;
        step();
        chk("glitch_pulse1", {31'd0, hit_pulse}, 0);
        step();
        chk("glitch_pulse2", {31'd0, hit_pulse}, 0);
        chk("glitch_hp", {28'd0, hp}, 5);
        chk("glitch_inv", {31'd0, invuln}, 0);

        // Async reset mid-INVULN, checked before any clock edge
        hit_once();
        chk("pre_rst_inv", {31'd0, invuln}, 1);
        repeat (3) frame_pulse(1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        #2 rst_n = 1'b1;
        step();
        chk_reset_vals("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
